// File: rtl/rr_mux_n.sv
// Registered N:1 word multiplexer, round-robin or fixed-select, with valid/ready on every side.
// Latency: one clk edge from input acceptance to out_valid; full throughput of one word per cycle.
// Backpressure: out_valid && !out_ready freezes the output register and drops every in_ready.
module rr_mux_n #(
  parameter int N     = 8,
  parameter int W     = 16,
  parameter int SEL_W = 3,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*W-1:0]     in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [W-1:0]       out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err,
  output logic [CNT_W-1:0]   xfer_cnt
);

  // Channel count and highest channel index at select width (+1 bit so N itself is representable).
  localparam logic [SEL_W:0]   NUM_CH  = (SEL_W+1)'(N);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N - 1);

  // Architectural state
  logic [W-1:0]     out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] last_grant_q, last_grant_d;
  logic             sel_err_q,   sel_err_d;
  logic [CNT_W-1:0] xfer_cnt_q,  xfer_cnt_d;

  // Arbitration intermediates
  logic             load;
  logic             sel_oob;
  logic [N-1:0]     elig;
  logic             found_hi, found_lo;
  logic [SEL_W-1:0] g_hi, g_lo;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_vld;

  // The output register can take a word when it is empty or its word leaves this cycle.
  assign load = !out_valid_q || out_ready;

  // A select outside 0..N-1 can only occur when N is not a power of two.
  assign sel_oob = ({1'b0, sel} >= NUM_CH);

  // Build the set of channels allowed to win this cycle for the current mode.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N; i++) begin
      if (mode) begin
        elig[i] = in_valid[i] && (sel == SEL_W'(i));
      end else begin
        elig[i] = in_valid[i];
      end
    end
  end

  // Round-robin pick: lowest eligible index above last_grant, else lowest eligible overall (wrap).
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    g_hi     = '0;
    g_lo     = '0;
    for (int i = 0; i < N; i++) begin
      if (elig[i]) begin
        if (!found_hi && (SEL_W'(i) > last_grant_q)) begin
          found_hi = 1'b1;
          g_hi     = SEL_W'(i);
        end
        if (!found_lo) begin
          found_lo = 1'b1;
          g_lo     = SEL_W'(i);
        end
      end
    end
    grant_idx = found_hi ? g_hi : g_lo;
  end

  // Reset suppresses any grant so no producer believes its word was taken.
  assign grant_vld = !rst && load && found_lo;

  // One-hot acceptance back to the winning producer.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = grant_vld && (grant_idx == SEL_W'(i));
    end
  end

  // Next-state for the output stage, arbitration pointer, error flag and counter.
  always_comb begin
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;
    xfer_cnt_d   = xfer_cnt_q;
    sel_err_d    = sel_err_q | (mode & sel_oob);

    if (grant_vld) begin
      for (int i = 0; i < N; i++) begin
        if (grant_idx == SEL_W'(i)) begin
          out_data_d = in_data[i*W +: W];
        end
      end
      out_sel_d    = grant_idx;
      out_valid_d  = 1'b1;
      last_grant_d = grant_idx;
      xfer_cnt_d   = xfer_cnt_q + 1'b1;
    end else if (load) begin
      // Held word consumed (or register already empty) and nothing new to take.
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; reset drops any held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q   <= '0;
      out_sel_q    <= '0;
      out_valid_q  <= 1'b0;
      last_grant_q <= LAST_CH;
      sel_err_q    <= 1'b0;
      xfer_cnt_q   <= '0;
    end else begin
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
      sel_err_q    <= sel_err_d;
      xfer_cnt_q   <= xfer_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_rr_mux_n.sv
// Bench for rr_mux_n: an 8-channel instance fed through a scoreboard, plus a
// 6-channel instance used for the out-of-range select case.
module tb_rr_mux_n;
  localparam int N     = 8;
  localparam int N6    = 6;
  localparam int W     = 16;
  localparam int SEL_W = 3;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  // 8-channel instance
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid, in_ready;
  logic             mode, out_ready, out_valid, sel_err;
  logic [SEL_W-1:0] sel, out_sel;
  logic [W-1:0]     out_data;
  logic [CNT_W-1:0] xfer_cnt;
  // 6-channel instance
  logic [N6*W-1:0]  in_data6;
  logic [N6-1:0]    in_valid6, in_ready6;
  logic             mode6, out_ready6, out_valid6, sel_err6;
  logic [SEL_W-1:0] sel6, out_sel6;
  logic [W-1:0]     out_data6;
  logic [CNT_W-1:0] xfer_cnt6;

  rr_mux_n #(.N(N), .W(W), .SEL_W(SEL_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err), .xfer_cnt(xfer_cnt)
  );

  rr_mux_n #(.N(N6), .W(W), .SEL_W(SEL_W), .CNT_W(CNT_W)) u_dut6 (
    .clk(clk), .rst(rst), .in_data(in_data6), .in_valid(in_valid6), .in_ready(in_ready6),
    .mode(mode6), .sel(sel6), .out_data(out_data6), .out_sel(out_sel6), .out_valid(out_valid6),
    .out_ready(out_ready6), .sel_err(sel_err6), .xfer_cnt(xfer_cnt6)
  );

  typedef struct packed {
    logic [W-1:0]     dat;
    logic [SEL_W-1:0] sel;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [W-1:0] base);
    for (int i = 0; i < N; i++) in_data[i*W +: W] = base + W'(i);
  endtask

  task automatic push(input logic [W-1:0] d, input logic [SEL_W-1:0] s);
    exp_t e;
    e.dat = d;
    e.sel = s;
    exp_q.push_back(e);
  endtask

  // Monitor: every word the consumer takes must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: actual %0h/%0d required none", out_data, out_sel);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_word", {13'd0, out_data, out_sel}, {13'd0, e.dat, e.sel});
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq2 [4];
    seq2 = '{2, 5, 2, 5};

    rst = 1'b1; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
    in_data6 = '0; in_valid6 = '0; mode6 = 1'b0; sel6 = '0; out_ready6 = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_sel",   32'(out_sel),   32'd0);
    chk("rst_sel_err",   32'(sel_err),   32'd0);
    chk("rst_xfer_cnt",  32'(xfer_cnt),  32'd0);
    step();

    // Round-robin over all eight channels: 0..7 then 0
    mode = 1'b0; out_ready = 1'b1; in_valid = '1; set_data(16'h1000);
    for (int k = 0; k < 9; k++) begin
      push(16'h1000 + 16'(k % 8), 3'(k % 8));
      @(negedge clk);
      chk("rr8_in_ready", 32'(in_ready), 32'(1 << (k % 8)));
      step();
    end
    in_valid = '0;
    @(negedge clk);
    chk("rr8_xfer_cnt", 32'(xfer_cnt), 32'd9);
    step();

    // Only channels 2 and 5 request: grants alternate
    in_valid = 8'b0010_0100;
    for (int k = 0; k < 4; k++) begin
      push(16'h1000 + 16'(seq2[k]), 3'(seq2[k]));
      @(negedge clk);
      chk("rr25_in_ready", 32'(in_ready), 32'(1 << seq2[k]));
      step();
    end
    in_valid = '0;
    step();
    @(negedge clk);
    chk("rr25_out_valid_idle", 32'(out_valid), 32'd0);
    chk("rr25_xfer_cnt", 32'(xfer_cnt), 32'd13);
    step();

    // Backpressure: word from channel 6 held three cycles, then no-bubble reload with 7
    in_valid = '1; out_ready = 1'b0;
    push(16'h1006, 3'd6);
    @(negedge clk);
    chk("bp_first_in_ready", 32'(in_ready), 32'h40);
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data_stable", 32'(out_data), 32'h1006);
      step();
    end
    out_ready = 1'b1;
    push(16'h1007, 3'd7);
    @(negedge clk);
    chk("bp_release_in_ready", 32'(in_ready), 32'h80);
    step();
    in_valid = '0;
    step();
    @(negedge clk);
    chk("bp_xfer_cnt", 32'(xfer_cnt), 32'd15);
    step();

    // Fixed select: sel=3 then sel=6
    mode = 1'b1; sel = 3'd3; set_data(16'hAAA0); in_valid = '1;
    for (int k = 0; k < 3; k++) begin
      push(16'hAAA3, 3'd3);
      @(negedge clk);
      chk("fix3_in_ready", 32'(in_ready), 32'h08);
      step();
    end
    sel = 3'd6;
    for (int k = 0; k < 2; k++) begin
      push(16'hAAA6, 3'd6);
      @(negedge clk);
      chk("fix6_in_ready", 32'(in_ready), 32'h40);
      step();
    end
    in_valid = '0; mode = 1'b0; sel = '0;
    step();
    @(negedge clk);
    chk("fix_xfer_cnt", 32'(xfer_cnt), 32'd20);
    step();

    // Six-channel instance: out-of-range select drains pending word and latches sel_err
    mode6 = 1'b1; sel6 = 3'd2; in_valid6 = '1; out_ready6 = 1'b0;
    for (int i = 0; i < N6; i++) in_data6[i*W +: W] = 16'h6000 + W'(i);
    @(negedge clk);
    chk("oob_pre_in_ready", 32'(in_ready6), 32'h04);
    step();
    sel6 = 3'd7; out_ready6 = 1'b1;
    @(negedge clk);
    chk("oob_in_ready", 32'(in_ready6), 32'd0);
    chk("oob_pending_valid", 32'(out_valid6), 32'd1);
    chk("oob_pending_data", 32'(out_data6), 32'h6002);
    chk("oob_pending_sel", 32'(out_sel6), 32'd2);
    chk("oob_sel_err_before", 32'(sel_err6), 32'd0);
    step();
    @(negedge clk);
    chk("oob_drained", 32'(out_valid6), 32'd0);
    chk("oob_sel_err_set", 32'(sel_err6), 32'd1);
    chk("oob_in_ready_still", 32'(in_ready6), 32'd0);
    step();
    mode6 = 1'b0; sel6 = '0; in_valid6 = '0;
    step(); step(); step();
    @(negedge clk);
    chk("oob_sel_err_sticky", 32'(sel_err6), 32'd1);
    chk("oob_xfer_cnt", 32'(xfer_cnt6), 32'd1);
    step();

    // Reset mid-stream with a held word; first grant after release is channel 0
    mode = 1'b0; set_data(16'h1000); in_valid = '1; out_ready = 1'b0;
    @(negedge clk);
    chk("mid_pre_in_ready", 32'(in_ready), 32'h80);
    step();
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("mid_held_valid", 32'(out_valid), 32'd1);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0; out_ready = 1'b0;
    push(16'h1000, 3'd0);
    @(negedge clk);
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_xfer_cnt", 32'(xfer_cnt), 32'd0);
    chk("mid_sel_err6", 32'(sel_err6), 32'd0);
    chk("mid_sel_err", 32'(sel_err), 32'd0);
    chk("mid_first_grant", 32'(in_ready), 32'h01);
    step();
    out_ready = 1'b1; in_valid = '0;
    step();
    @(negedge clk);
    chk("mid_xfer_cnt_after", 32'(xfer_cnt), 32'd1);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
